// File: rtl/branch_target_buffer_if.sv
// Lookup/update bus for the branch target buffer. The fetch side drives PC and reads hit/taken/PC_Target.
// The EX side drives an update, qualified by ID_EX_Branch. rr_ptr is a debug view of the replacement pointer.
interface branch_target_buffer_if;
    logic [31:0] PC;
    logic [31:0] ID_EX_PC;
    logic        ID_EX_Branch;
    logic        Pcsrc;
    logic [31:0] Branch_Target;
    logic        hit;
    logic        taken;
    logic [31:0] PC_Target;
    logic [2:0]  rr_ptr;

    // There is no handshake: an update is accepted on every rising edge where ID_EX_Branch = 1.
    // A lookup is a pure combinational read of PC, and it is never stalled.
    modport master (
        output PC, ID_EX_PC, ID_EX_Branch, Pcsrc, Branch_Target,
        input  hit, taken, PC_Target, rr_ptr
    );

    modport slave (
        input  PC, ID_EX_PC, ID_EX_Branch, Pcsrc, Branch_Target,
        output hit, taken, PC_Target, rr_ptr
    );
endinterface

// File: rtl/branch_target_buffer.sv
// 8-entry fully-associative branch target buffer with 2-bit saturating direction counters.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update of the looked-up PC to the lookup outputs.
module branch_target_buffer (
    input  logic                         clk,
    input  logic                         reset,
    branch_target_buffer_if.slave        bus
);
    logic [7:0]  r_valid;
    logic [31:0] r_tag    [8];
    logic [31:0] r_target [8];
    logic [1:0]  r_ctr    [8];
    logic [2:0]  r_rr_ptr;

    logic        w_lk_hit;
    logic [2:0]  w_lk_idx;
    logic        w_upd_hit;
    logic [2:0]  w_upd_idx;
    logic        w_free_found;
    logic [2:0]  w_free_idx;
    logic [2:0]  w_victim;
    logic [1:0]  w_new_ctr;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
        if (t)
            return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else
            return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Descending scans make the lowest matching index the final assignment.
    always_comb begin
        w_lk_hit     = 1'b0;
        w_lk_idx     = 3'd0;
        w_upd_hit    = 1'b0;
        w_upd_idx    = 3'd0;
        w_free_found = 1'b0;
        w_free_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == bus.PC)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = i[2:0];
            end
            if (r_valid[i] && (r_tag[i] == bus.ID_EX_PC)) begin
                w_upd_hit = 1'b1;
                w_upd_idx = i[2:0];
            end
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = i[2:0];
            end
        end
    end

    always_comb begin
        w_victim  = w_free_found ? w_free_idx : r_rr_ptr;
        w_new_ctr = w_upd_hit ? ctr_next(r_ctr[w_upd_idx], bus.Pcsrc)
                              : (bus.Pcsrc ? 2'b10 : 2'b01);
    end

    always_comb begin
        bus.hit       = w_lk_hit;
        bus.taken     = w_lk_hit ? r_ctr[w_lk_idx][1] : 1'b0;
        bus.PC_Target = w_lk_hit ? r_target[w_lk_idx] : 32'd0;
`ifdef BTB_BYPASS_EN
        // A same-cycle update of this PC wins, whether it updates an entry or allocates one.
        if (bus.ID_EX_Branch && (bus.ID_EX_PC == bus.PC)) begin
            bus.hit       = 1'b1;
            bus.taken     = w_new_ctr[1];
            bus.PC_Target = bus.Branch_Target;
        end
`endif
        bus.rr_ptr = r_rr_ptr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= 32'd0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= 2'b00;
            end
            r_rr_ptr <= 3'd0;
        end else if (bus.ID_EX_Branch) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx]    <= w_new_ctr;
                r_target[w_upd_idx] <= bus.Branch_Target;
            end else begin
                r_valid[w_victim]  <= 1'b1;
                r_tag[w_victim]    <= bus.ID_EX_PC;
                r_target[w_victim] <= bus.Branch_Target;
                r_ctr[w_victim]    <= w_new_ctr;
                // The pointer only moves when a live entry is evicted.
                if (!w_free_found)
                    r_rr_ptr <= r_rr_ptr + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: lookups, counter saturation, round-robin eviction, bypass, and reset priority.
module tb_branch_target_buffer;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    logic [33:0] exp_q [$];
    logic [31:0] tgt   [10];

    branch_target_buffer_if bus ();

    branch_target_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.PC            = 32'd0;
        bus.ID_EX_PC      = 32'd0;
        bus.ID_EX_Branch  = 1'b0;
        bus.Pcsrc         = 1'b0;
        bus.Branch_Target = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input logic [33:0] got);
        logic [33:0] exp;
        exp = exp_q.pop_front();
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_lookup(input string tag, input logic [31:0] pc,
                                input logic eh, input logic et, input logic [31:0] etg);
        bus.PC = pc;
        exp_q.push_back({eh, et, etg});
        @(negedge clk);
        compare(tag, {bus.hit, bus.taken, bus.PC_Target});
    endtask

    task automatic check_rr(input string tag, input logic [2:0] erp);
        exp_q.push_back({31'd0, erp});
        @(negedge clk);
        compare(tag, {31'd0, bus.rr_ptr});
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] target);
        bus.ID_EX_PC      = pc;
        bus.Pcsrc         = t;
        bus.Branch_Target = target;
        bus.ID_EX_Branch  = 1'b1;
        step();
        bus.ID_EX_Branch  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        do_reset();

        check_lookup("reset_miss_100", 32'h100, 1'b0, 1'b0, 32'd0);
        check_lookup("reset_miss_0", 32'h0, 1'b0, 1'b0, 32'd0);
        check_rr("reset_rr", 3'd0);

        update(32'h100, 1'b1, 32'h200);
        check_lookup("alloc_taken", 32'h100, 1'b1, 1'b1, 32'h200);
        update(32'h100, 1'b0, 32'h200);
        check_lookup("nt1_ctr01", 32'h100, 1'b1, 1'b0, 32'h200);
        update(32'h100, 1'b0, 32'h200);
        check_lookup("nt2_ctr00", 32'h100, 1'b1, 1'b0, 32'h200);
        update(32'h100, 1'b0, 32'h200);
        check_lookup("nt3_sat00", 32'h100, 1'b1, 1'b0, 32'h200);
        update(32'h100, 1'b1, 32'h200);
        check_lookup("t_ctr01", 32'h100, 1'b1, 1'b0, 32'h200);
        update(32'h100, 1'b1, 32'h208);
        check_lookup("t_ctr10_newtgt", 32'h100, 1'b1, 1'b1, 32'h208);
        update(32'h100, 1'b1, 32'h208);
        update(32'h100, 1'b1, 32'h208);
        update(32'h100, 1'b0, 32'h208);
        check_lookup("sat11_then_nt", 32'h100, 1'b1, 1'b1, 32'h208);

        update(32'h180, 1'b0, 32'h1c0);
        check_lookup("alloc_not_taken", 32'h180, 1'b1, 1'b0, 32'h1c0);

        do_reset();
        check_lookup("reset_clears_100", 32'h100, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++)
            tgt[i] = {$urandom_range(32'hffff, 1), 2'b00};
        for (int i = 0; i < 8; i++)
            update(32'(i * 4), 1'b1, tgt[i]);
        check_rr("full_rr0", 3'd0);
        check_lookup("full_entry7", 32'h1c, 1'b1, 1'b1, tgt[7]);
        update(32'h20, 1'b1, tgt[8]);
        check_lookup("evict0_miss", 32'h0, 1'b0, 1'b0, 32'd0);
        check_lookup("evict0_new", 32'h20, 1'b1, 1'b1, tgt[8]);
        check_lookup("evict0_keep4", 32'h4, 1'b1, 1'b1, tgt[1]);
        check_rr("evict0_rr1", 3'd1);
        update(32'h24, 1'b0, tgt[9]);
        check_lookup("evict1_miss", 32'h4, 1'b0, 1'b0, 32'd0);
        check_lookup("evict1_new", 32'h24, 1'b1, 1'b0, tgt[9]);
        check_lookup("evict1_keep8", 32'h8, 1'b1, 1'b1, tgt[2]);
        check_rr("evict1_rr2", 3'd2);
        update(32'h8, 1'b0, 32'h888);
        check_rr("upd_hit_rr_hold", 3'd2);
        check_lookup("upd_hit_full", 32'h8, 1'b1, 1'b0, 32'h888);

        do_reset();
        bus.PC = 32'h300;
        bus.ID_EX_PC = 32'h300;
        bus.Pcsrc = 1'b1;
        bus.Branch_Target = 32'h340;
        bus.ID_EX_Branch = 1'b1;
`ifdef BTB_BYPASS_EN
        exp_q.push_back({1'b1, 1'b1, 32'h340});
`else
        exp_q.push_back({1'b0, 1'b0, 32'h0});
`endif
        @(negedge clk);
        compare("same_cycle_300", {bus.hit, bus.taken, bus.PC_Target});
        step();
        bus.ID_EX_Branch = 1'b0;
        check_lookup("after_300", 32'h300, 1'b1, 1'b1, 32'h340);

        bus.ID_EX_PC = 32'h500;
        bus.Pcsrc = 1'b0;
        bus.Branch_Target = 32'h540;
        bus.ID_EX_Branch = 1'b1;
        check_lookup("concurrent_lookup", 32'h300, 1'b1, 1'b1, 32'h340);
        step();
        bus.ID_EX_Branch = 1'b0;
        check_lookup("concurrent_update", 32'h500, 1'b1, 1'b0, 32'h540);

        bus.ID_EX_PC = 32'h400;
        bus.Pcsrc = 1'b1;
        bus.Branch_Target = 32'h440;
        bus.ID_EX_Branch = 1'b1;
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.ID_EX_Branch = 1'b0;
        check_lookup("reset_beats_update", 32'h400, 1'b0, 1'b0, 32'd0);
        check_lookup("reset_mid_op_300", 32'h300, 1'b0, 1'b0, 32'd0);
        check_rr("reset_mid_op_rr", 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL expose: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL expose: PC  input  32  fetch-stage PC to look up.
REQ-004 SHALL expose: ID_EX_PC  input  32  PC of the instruction resolving in EX.
REQ-005 SHALL expose: ID_EX_Branch  input  1  EX instruction is a conditional branch; qualifies the update.
REQ-006 SHALL expose: Pcsrc  input  1  actual branch outcome, 1 = taken.
REQ-007 SHALL expose: Branch_Target  input  32  resolved branch target from EX.
REQ-008 SHALL expose: hit  output  1  PC matches a valid entry.
REQ-009 SHALL expose: taken  output  1  predicted taken.
REQ-010 SHALL expose: PC_Target  output  32  stored target of the matching entry.

Function
REQ-011 SHALL hold 8 fully-associative entries, each with: valid, 32-bit tag (full PC), 32-bit target, 2-bit saturating counter.
REQ-012 Lookup SHALL be combinational from registered state: hit = any valid entry with tag == PC; lowest index wins on multiple matches.
REQ-013 On hit: taken = counter[1]; PC_Target = entry target. On miss: taken = 0, PC_Target = 32'd0.
REQ-014 Update SHALL occur only in cycles with ID_EX_Branch = 1; when ID_EX_Branch = 0, no state SHALL change.
REQ-015 Update on tag match (ID_EX_PC): counter +1 saturating at 2'b11 if Pcsrc = 1, -1 saturating at 2'b00 if Pcsrc = 0; target <= Branch_Target.
REQ-016 Update on tag miss: allocate victim; valid <= 1, tag <= ID_EX_PC, target <= Branch_Target, counter <= 2'b10 if Pcsrc else 2'b01.
REQ-017 Victim selection: lowest-index invalid entry; if all 8 valid, entry at 3-bit round-robin pointer rr_ptr.
REQ-018 rr_ptr SHALL advance by 1 (wrapping 7 -> 0) only on an allocation that evicts a valid entry.
REQ-019 Allocation SHALL occur only on miss, so a tag SHALL never be present in two entries.
REQ-020 Update effects SHALL become visible to lookup in the cycle after the update edge (1-cycle latency) unless REQ-026 applies.
REQ-021 Simultaneous lookup and update to different PCs SHALL both proceed without interference.

Reset
REQ-022 When reset = 0 at a rising clk edge: all valid <= 0, counters <= 2'b00, tags/targets <= 32'd0, rr_ptr <= 3'd0.
REQ-023 After reset, hit = 0, taken = 0, PC_Target = 32'd0 for any PC.
REQ-024 Reset SHALL take priority over a concurrent update; that update SHALL be discarded.
REQ-025 Reset mid-operation SHALL leave no entry valid; no partial update SHALL survive.

Configuration
REQ-026 Macro BTB_BYPASS_EN: when defined, if ID_EX_Branch = 1 and ID_EX_PC == PC in the same cycle, hit/taken/PC_Target SHALL reflect the post-update entry values (forwarded); when undefined, lookup SHALL return pre-update state per REQ-020.

Verification
REQ-027 Reset, then PC=0x100 -> hit=0, taken=0, PC_Target=0.
REQ-028 Update ID_EX_PC=0x100, Pcsrc=1, Branch_Target=0x200; next cycle PC=0x100 -> hit=1, taken=1 (ctr=2'b10), PC_Target=0x200.
REQ-029 Three further not-taken updates on 0x100 -> counter 10->01->00->00 (saturates); lookup gives taken=0, PC_Target=0x200.
REQ-030 Allocate 9 distinct PCs 0x0,0x4,...,0x20 -> 9th evicts entry 0 (PC 0x0 misses), rr_ptr=1; 10th evicts entry 1.
REQ-031 Same cycle PC=ID_EX_PC=0x300 (new), Pcsrc=1, Branch_Target=0x340 -> hit=0 without BTB_BYPASS_EN; hit=1, taken=1, PC_Target=0x340 with it.
REQ-032 Assert reset in the same cycle as an update of 0x400 -> next cycle PC=0x400 gives hit=0.
